// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: port count, destination
// field width, FSM state encoding and a destination-field extractor.
// Latency: n/a (declarations only). Backpressure: n/a.
package arb_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DEST_W    = 2;
  // Widest word the destination helper accepts; callers zero-extend to this.
  localparam int WORD_MAX  = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Destination lives in the two MSBs of a word that is 'width' bits wide.
  function automatic logic [DEST_W-1:0] dest_of(input logic [WORD_MAX-1:0] word,
                                                input int                  width);
    logic [WORD_MAX-1:0] shifted;
    shifted = word >> (width - DEST_W);
    return shifted[DEST_W-1:0];
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant picker: first eligible input at or after rr_ptr, mod 4.
// Latency: purely combinational. Backpressure: none; eligibility already
// folds in output almost-full.
// Ports: eligible (per-input request), rr_ptr (search start),
//        grant (one-hot winner), valid (any winner).
module rr_grant
  import arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [1:0]           rr_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 valid
);

  logic [1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      // 2-bit add wraps 3 -> 0 naturally.
      idx = rr_ptr + 2'(k);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains four FWFT input FIFOs round-robin, routing each word to the output
// FIFO named by its two MSBs. Latency: pop is combinational, push/data_out
// follow one cycle later. Backpressure: an input whose head targets an
// almost-full output is skipped (never popped); other inputs proceed.
// Ports: clk, reset (async active-low), fifo_empty/fifo_data_out (input bank
//        heads), out_almost_full (output bank), pop (to inputs), push/data_out
//        (to outputs), active (FSM in ACTIVE).
// Optional: define ARB_PKT_COUNT_EN to add pkt_count, four saturating 8-bit
//        per-destination push counters (dest i at [8*i +: 8]).
module fifo_rr_arbiter
  import arb_pkg::*;
#(
  parameter int data_width = 10,
  parameter int num_ports  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [num_ports-1:0]            fifo_empty,
  input  logic [num_ports*data_width-1:0] fifo_data_out,
  input  logic [num_ports-1:0]            out_almost_full,
  output logic [num_ports-1:0]            pop,
  output logic [num_ports-1:0]            push,
  output logic [data_width-1:0]           data_out,
  output logic                            active
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [num_ports*8-1:0]          pkt_count
`endif
);

  logic [data_width-1:0] head      [NUM_PORTS];
  logic [DEST_W-1:0]     head_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  grant;
  logic                  grant_vld;
  logic [1:0]            gidx;
  logic [1:0]            rr_ptr;
  state_t                state;
  state_t                state_nxt;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_head
    assign head[i]      = fifo_data_out[i*data_width +: data_width];
    assign head_dest[i] = dest_of(WORD_MAX'(head[i]), data_width);
    // almost_full is sampled here, one cycle before the push lands; output
    // FIFOs carry the extra entry of margin.
    assign eligible[i]  = !fifo_empty[i] && !out_almost_full[head_dest[i]];
  end

  rr_grant u_rr_grant (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .valid    (grant_vld)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) gidx = 2'(i);
    end
  end

  // Gate pop while reset is held so the input bank never loses a word.
  assign pop = reset ? grant : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible)  state_nxt = ACTIVE;
      ACTIVE:  if (!(|eligible)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign active = (state == ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      push     <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        data_out <= head[gidx];
        push     <= NUM_PORTS'(1) << head_dest[gidx];
        rr_ptr   <= gidx + 2'd1;
      end else begin
        push <= '0;
      end
    end
  end

`ifdef ARB_PKT_COUNT_EN
  logic [7:0] cnt [NUM_PORTS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i] && (cnt[i] != 8'hFF)) cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_count[i*8 +: 8] = cnt[i];
  end
`endif

endmodule
